// File: rtl/if_stage.sv
// rtl/if_stage.sv - instruction fetch stage with direct-mapped icache and single-outstanding refill
package if_stage_pkg;
  localparam int StallLevelLen = 2;
  typedef enum logic [StallLevelLen-1:0] {
    Stall_Null   = 2'd0,
    Stall_Decode = 2'd1,
    Stall_Issue  = 2'd2,
    Stall_All    = 2'd3
  } stall_level_e;
  localparam logic [31:0] ZeroWord = 32'h0;
endpackage

module if_stage
  import if_stage_pkg::*;
#(
  parameter int          ICACHE_LINES = 64,
  parameter logic [31:0] RESET_PC     = 32'h0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     rdy,
  input  logic [StallLevelLen-1:0] stall_command,
  input  logic                     jump_ex_en,
  input  logic [31:0]              jump_ex_target,
  input  logic                     jump_id_en,
  input  logic [31:0]              jump_id_target,
  output logic                     mem_req,
  output logic [31:0]              mem_addr,
  input  logic                     mem_ack,
  input  logic [31:0]              mem_data,
  output logic [31:0]              if_pc,
  output logic [31:0]              if_inst,
  output logic                     stall_req_if
);
  localparam int IdxW = $clog2(ICACHE_LINES);
  localparam int TagW = 30 - IdxW;

  typedef enum logic {S_IDLE, S_WAIT} state_e;

  state_e                  state_q, state_d;
  logic [31:0]             pc_q, pc_d;
  logic                    mem_req_q, mem_req_d;
  logic [31:0]             fetch_addr_q, fetch_addr_d;
  logic [ICACHE_LINES-1:0] valid_q, valid_d;
  logic [TagW-1:0]         tag_q  [ICACHE_LINES];
  logic [31:0]             data_q [ICACHE_LINES];
  logic                    fill_en;

  logic [IdxW-1:0] pc_idx, fill_idx;
  logic [TagW-1:0] pc_tag, fill_tag;
  logic            hit, jump_any;

  assign pc_idx   = pc_q[IdxW+1:2];
  assign pc_tag   = pc_q[31:IdxW+2];
  assign fill_idx = fetch_addr_q[IdxW+1:2];
  assign fill_tag = fetch_addr_q[31:IdxW+2];
  assign hit      = valid_q[pc_idx] && (tag_q[pc_idx] == pc_tag);
  assign jump_any = jump_ex_en || jump_id_en;

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    mem_req_d    = mem_req_q;
    fetch_addr_d = fetch_addr_q;
    valid_d      = valid_q;
    fill_en      = 1'b0;
    if (rdy) begin
      case (state_q)
        S_IDLE: begin
          // A redirect this cycle makes the miss stale, so no request goes out.
          if (!hit && !jump_any) begin
            state_d      = S_WAIT;
            mem_req_d    = 1'b1;
            fetch_addr_d = {pc_q[31:2], 2'b00};
          end
        end
        S_WAIT: begin
          if (mem_ack) begin
            state_d           = S_IDLE;
            mem_req_d         = 1'b0;
            fill_en           = 1'b1;
            valid_d[fill_idx] = 1'b1;
          end
        end
        default: state_d = S_IDLE;
      endcase

      if (jump_ex_en) begin
        pc_d = jump_ex_target;
      end else if (stall_command == Stall_All || stall_command == Stall_Issue) begin
        pc_d = pc_q;
      end else if (jump_id_en) begin
        pc_d = jump_id_target;
      end else if (stall_command == Stall_Null && hit) begin
        pc_d = pc_q + 32'd4;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      pc_q         <= RESET_PC;
      mem_req_q    <= 1'b0;
      fetch_addr_q <= 32'h0;
      valid_q      <= '0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      mem_req_q    <= mem_req_d;
      fetch_addr_q <= fetch_addr_d;
      valid_q      <= valid_d;
    end
  end

  // Tag/data need no reset: every read is qualified by the valid bit.
  always_ff @(posedge clk) begin
    if (fill_en) begin
      tag_q[fill_idx]  <= fill_tag;
      data_q[fill_idx] <= mem_data;
    end
  end

  assign mem_req      = mem_req_q;
  assign mem_addr     = fetch_addr_q;
  assign if_pc        = pc_q;
  assign if_inst      = hit ? data_q[pc_idx] : ZeroWord;
  assign stall_req_if = !hit;
endmodule

// File: tb/tb_if_stage.sv
// tb/tb_if_stage.sv - self-checking bench for if_stage against a line-address cache model
module tb_if_stage;
  import if_stage_pkg::*;

  logic                     clk = 1'b0;
  logic                     rst;
  logic                     rdy;
  logic [StallLevelLen-1:0] stall_command;
  logic                     jump_ex_en;
  logic [31:0]              jump_ex_target;
  logic                     jump_id_en;
  logic [31:0]              jump_id_target;
  logic                     mem_req;
  logic [31:0]              mem_addr;
  logic                     mem_ack;
  logic [31:0]              mem_data;
  logic [31:0]              if_pc;
  logic [31:0]              if_inst;
  logic                     stall_req_if;

  int errors = 0;
  int checks = 0;
  int lat_cnt = 0;

  // Model: cache as a map from line index to the word address it holds.
  logic [31:0] m_pc;
  logic [31:0] m_fetch;
  logic        m_busy;
  logic [31:0] m_line_addr [int];

  if_stage #(.ICACHE_LINES(64), .RESET_PC(32'h0)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .stall_command(stall_command),
    .jump_ex_en(jump_ex_en), .jump_ex_target(jump_ex_target),
    .jump_id_en(jump_id_en), .jump_id_target(jump_id_target),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_data(mem_data),
    .if_pc(if_pc), .if_inst(if_inst), .stall_req_if(stall_req_if)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0) return 32'h00000013;
    return (a * 32'h0019660D) ^ 32'h3C6EF35F;
  endfunction

  function automatic logic m_hit();
    int i;
    i = int'(m_pc[7:2]);
    if (!m_line_addr.exists(i)) return 1'b0;
    return m_line_addr[i] == {m_pc[31:2], 2'b00};
  endfunction

  function automatic logic [97:0] exp_vec();
    logic h;
    h = m_hit();
    return {m_pc, (h ? mem_word({m_pc[31:2], 2'b00}) : 32'h0), !h, m_busy, m_fetch};
  endfunction

  function automatic logic [97:0] obs_vec();
    return {if_pc, if_inst, stall_req_if, mem_req, mem_addr};
  endfunction

  task automatic model_reset();
    m_pc = 32'h0;
    m_fetch = 32'h0;
    m_busy = 1'b0;
    m_line_addr.delete();
    lat_cnt = 0;
  endtask

  task automatic model_edge();
    logic h;
    if (!rst || !rdy) return;
    h = m_hit();
    if (m_busy) begin
      if (mem_ack) begin
        m_line_addr[int'(m_fetch[7:2])] = m_fetch;
        m_busy = 1'b0;
      end
    end else if (!h && !jump_ex_en && !jump_id_en) begin
      m_busy = 1'b1;
      m_fetch = {m_pc[31:2], 2'b00};
    end
    if (jump_ex_en) m_pc = jump_ex_target;
    else if (!(stall_command == Stall_All || stall_command == Stall_Issue)) begin
      if (jump_id_en) m_pc = jump_id_target;
      else if (stall_command == Stall_Null && h) m_pc = m_pc + 32'd4;
    end
  endtask

  task automatic tick(input logic ack);
    mem_ack = ack;
    mem_data = mem_word(mem_addr);
    @(posedge clk);
    model_edge();
    #1;
    mem_ack = 1'b0;
    jump_ex_en = 1'b0;
    jump_id_en = 1'b0;
  endtask

  task automatic tick_auto();
    if (m_busy && rdy) begin
      if (lat_cnt == 0) lat_cnt = $urandom_range(1, 4);
      lat_cnt--;
      tick(lat_cnt == 0);
    end else begin
      tick(1'b0);
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && (mem_req || m_busy); i++) tick_auto();
    checks++;
    if (mem_req !== 1'b0) begin errors++; $display("FAIL drain_timeout: mem_req=%b required 0", mem_req); end
  endtask

  function automatic logic [31:0] rnd_target();
    logic [31:0] t;
    t = ($urandom_range(0, 127) << 2) | $urandom_range(0, 3);
    if ($urandom_range(0, 7) == 0) t = 32'hFFFFFF00 | {24'h0, t[7:0]};
    return t;
  endfunction

  task automatic test_reset();
    rst = 1'b0;
    model_reset();
    #1;
    for (int i = 0; i < 3; i++) begin
      tick(1'b1);
      checks++;
      if (obs_vec() !== exp_vec()) begin errors++; $display("FAIL reset_vec: got %h required %h", obs_vec(), exp_vec()); end
    end
    checks++;
    if ({stall_req_if, if_inst, mem_req, mem_addr, if_pc} !== {1'b1, 32'h0, 1'b0, 32'h0, 32'h0}) begin
      errors++;
      $display("FAIL reset_const: stall=%b inst=%h req=%b addr=%h pc=%h required 1/0/0/0/0", stall_req_if, if_inst, mem_req, mem_addr, if_pc);
    end
  endtask

  task automatic test_first_miss();
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick(1'b0);
      checks++;
      if (mem_req !== 1'b1 || mem_addr !== 32'h0 || obs_vec() !== exp_vec()) begin
        errors++; $display("FAIL first_req: req=%b addr=%h required 1/00000000", mem_req, mem_addr);
      end
    end
    tick(1'b1);
    checks++;
    if (if_inst !== 32'h13 || stall_req_if !== 1'b0 || mem_req !== 1'b0 || if_pc !== 32'h0) begin
      errors++; $display("FAIL first_fill: inst=%h stall=%b req=%b pc=%h required 00000013/0/0/0", if_inst, stall_req_if, mem_req, if_pc);
    end
    tick(1'b0);
    checks++;
    if (if_pc !== 32'h4) begin errors++; $display("FAIL first_advance: pc=%h required 00000004", if_pc); end
  endtask

  task automatic test_sequential();
    for (int i = 0; i < 60 && m_pc != 32'd16; i++) begin
      tick_auto();
      checks++;
      if (obs_vec() !== exp_vec()) begin errors++; $display("FAIL preload_vec: got %h required %h", obs_vec(), exp_vec()); end
    end
    jump_ex_en = 1'b1;
    jump_ex_target = 32'h0;
    tick(1'b0);
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (if_pc !== 32'(k * 4) || mem_req !== 1'b0 || stall_req_if !== 1'b0) begin
        errors++; $display("FAIL seq_hit: pc=%h req=%b stall=%b required pc=%h 0/0", if_pc, mem_req, stall_req_if, 32'(k * 4));
      end
      tick(1'b0);
    end
    drain();
  endtask

  task automatic test_stall_jump();
    logic [31:0] p;
    p = m_pc;
    stall_command = Stall_Issue;
    jump_id_en = 1'b1;
    jump_id_target = 32'h200;
    tick(1'b0);
    checks++;
    if (if_pc !== p) begin errors++; $display("FAIL issue_hold: pc=%h required %h", if_pc, p); end
    jump_id_en = 1'b1;
    jump_id_target = 32'h200;
    jump_ex_en = 1'b1;
    jump_ex_target = 32'h100;
    tick(1'b0);
    checks++;
    if (if_pc !== 32'h100) begin errors++; $display("FAIL ex_over_stall: pc=%h required 00000100", if_pc); end
    stall_command = Stall_Decode;
    jump_id_en = 1'b1;
    jump_id_target = 32'h104;
    tick(1'b0);
    checks++;
    if (if_pc !== 32'h104) begin errors++; $display("FAIL decode_id_jump: pc=%h required 00000104", if_pc); end
    tick(1'b0);
    checks++;
    if (if_pc !== 32'h104 || mem_req !== 1'b1 || mem_addr !== 32'h104) begin
      errors++; $display("FAIL decode_refill: pc=%h req=%b addr=%h required 00000104/1/00000104", if_pc, mem_req, mem_addr);
    end
    stall_command = Stall_Null;
    drain();
  endtask

  task automatic test_jump_during_wait();
    jump_ex_en = 1'b1;
    jump_ex_target = 32'h40;
    tick(1'b0);
    tick(1'b0);
    checks++;
    if (mem_req !== 1'b1 || mem_addr !== 32'h40) begin errors++; $display("FAIL jw_req: req=%b addr=%h required 1/00000040", mem_req, mem_addr); end
    jump_ex_en = 1'b1;
    jump_ex_target = 32'h80;
    tick(1'b0);
    checks++;
    if (if_pc !== 32'h80 || mem_addr !== 32'h40 || mem_req !== 1'b1) begin
      errors++; $display("FAIL jw_redirect: pc=%h addr=%h req=%b required 00000080/00000040/1", if_pc, mem_addr, mem_req);
    end
    tick(1'b0);
    checks++;
    if (mem_addr !== 32'h40 || obs_vec() !== exp_vec()) begin errors++; $display("FAIL jw_hold: got %h required %h", obs_vec(), exp_vec()); end
    tick(1'b1);
    checks++;
    if (mem_req !== 1'b0 || stall_req_if !== 1'b1) begin errors++; $display("FAIL jw_ack: req=%b stall=%b required 0/1", mem_req, stall_req_if); end
    tick(1'b0);
    checks++;
    if (mem_req !== 1'b1 || mem_addr !== 32'h80) begin errors++; $display("FAIL jw_new_req: req=%b addr=%h required 1/00000080", mem_req, mem_addr); end
    drain();
    jump_ex_en = 1'b1;
    jump_ex_target = 32'h40;
    tick(1'b0);
    checks++;
    if (stall_req_if !== 1'b0 || if_inst !== mem_word(32'h40)) begin
      errors++; $display("FAIL jw_line16: stall=%b inst=%h required 0/%h", stall_req_if, if_inst, mem_word(32'h40));
    end
    drain();
  endtask

  task automatic test_rdy_freeze();
    jump_ex_en = 1'b1;
    jump_ex_target = 32'h300;
    tick(1'b0);
    tick(1'b0);
    rdy = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if (k == 2) begin jump_ex_en = 1'b1; jump_ex_target = 32'h10; end
      tick(k == 1);
      checks++;
      if (mem_req !== 1'b1 || if_pc !== 32'h300 || mem_addr !== 32'h300 || obs_vec() !== exp_vec()) begin
        errors++; $display("FAIL freeze: req=%b pc=%h addr=%h required 1/00000300/00000300", mem_req, if_pc, mem_addr);
      end
    end
    rdy = 1'b1;
    tick(1'b0);
    checks++;
    if (mem_req !== 1'b1 || stall_req_if !== 1'b1) begin errors++; $display("FAIL freeze_resume: req=%b stall=%b required 1/1", mem_req, stall_req_if); end
    drain();
  endtask

  task automatic test_wrap();
    jump_ex_en = 1'b1;
    jump_ex_target = 32'hFFFFFFFC;
    tick(1'b0);
    for (int i = 0; i < 20 && stall_req_if !== 1'b0; i++) tick_auto();
    checks++;
    if (stall_req_if !== 1'b0 || if_pc !== 32'hFFFFFFFC) begin
      errors++; $display("FAIL wrap_fill: stall=%b pc=%h required 0/fffffffc", stall_req_if, if_pc);
    end
    tick(1'b0);
    checks++;
    if (if_pc !== 32'h0 || obs_vec() !== exp_vec()) begin errors++; $display("FAIL wrap_pc: pc=%h required 00000000", if_pc); end
    drain();
  endtask

  task automatic test_reset_mid_wait();
    logic [31:0] probe [5];
    probe = '{32'h4, 32'h8, 32'h40, 32'h80, 32'hFFFFFFFC};
    jump_ex_en = 1'b1;
    jump_ex_target = 32'h500;
    tick(1'b0);
    tick(1'b0);
    checks++;
    if (mem_req !== 1'b1) begin errors++; $display("FAIL rst_pre_wait: req=%b required 1", mem_req); end
    #2;
    rst = 1'b0;
    model_reset();
    #1;
    checks++;
    if (mem_req !== 1'b0 || stall_req_if !== 1'b1 || if_pc !== 32'h0 || obs_vec() !== exp_vec()) begin
      errors++; $display("FAIL rst_async: req=%b stall=%b pc=%h required 0/1/00000000", mem_req, stall_req_if, if_pc);
    end
    tick(1'b0);
    rst = 1'b1;
    tick(1'b1);
    checks++;
    if (mem_req !== 1'b1 || mem_addr !== 32'h0 || stall_req_if !== 1'b1) begin
      errors++; $display("FAIL rst_idle_ack: req=%b addr=%h stall=%b required 1/00000000/1", mem_req, mem_addr, stall_req_if);
    end
    foreach (probe[i]) begin
      jump_ex_en = 1'b1;
      jump_ex_target = probe[i];
      tick(1'b0);
      checks++;
      if (stall_req_if !== 1'b1 || if_inst !== 32'h0) begin
        errors++; $display("FAIL rst_invalid: addr=%h stall=%b inst=%h required 1/00000000", probe[i], stall_req_if, if_inst);
      end
    end
    drain();
  endtask

  task automatic test_random();
    int v;
    for (int c = 0; c < 3000; c++) begin
      rdy = ($urandom_range(0, 9) != 0);
      v = $urandom_range(0, 9);
      stall_command = (v < 6) ? 2'd0 : 2'(v - 6);
      jump_ex_en = ($urandom_range(0, 24) == 0);
      jump_ex_target = rnd_target();
      jump_id_en = ($urandom_range(0, 9) == 0);
      jump_id_target = rnd_target();
      if (!m_busy && $urandom_range(0, 19) == 0) tick(1'b1);
      else tick_auto();
      checks++;
      if (obs_vec() !== exp_vec()) begin errors++; $display("FAIL random_vec cycle %0d: got %h required %h", c, obs_vec(), exp_vec()); end
    end
    rdy = 1'b1;
    stall_command = Stall_Null;
  endtask

  initial begin
    rst = 1'b1;
    rdy = 1'b1;
    stall_command = Stall_Null;
    jump_ex_en = 1'b0;
    jump_ex_target = 32'h0;
    jump_id_en = 1'b0;
    jump_id_target = 32'h0;
    mem_ack = 1'b0;
    mem_data = 32'h0;
    model_reset();
    #2;
    test_reset();
    test_first_miss();
    test_sequential();
    test_stall_jump();
    test_jump_during_wait();
    test_rdy_freeze();
    test_wrap();
    test_reset_mid_wait();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
